// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver FSM state encoding
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE_LVL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sfifo.sv
// rtl/uart_rx_sfifo.sv - synchronous first-word-fall-through FIFO for received bytes
module uart_rx_sfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampling 8N1 UART receiver with byte FIFO and sticky errors
// Optional 8E1 parity checking and par_err port enabled by UART_RX_PARITY_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rx_valid,
    output logic       fifo_full,
    output logic       overrun,
    output logic       frame_err,
    input  logic       err_clr
`ifdef UART_RX_PARITY_EN
    ,
    output logic       par_err
`endif
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

    uart_state_t               state;
    uart_state_t               state_nx;
    logic                      rxd_m;
    logic                      rxd_s;
    logic [CW-1:0]             clk_cnt;
    logic [BW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      half_tick;
    logic                      full_tick;
    logic                      push;
    logic                      frame_set;
    logic                      ovr_set;
    logic                      fifo_empty;
`ifdef UART_RX_PARITY_EN
    logic                      par_set;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_m <= UART_IDLE_LVL;
            rxd_s <= UART_IDLE_LVL;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    assign half_tick = (clk_cnt == CNT_HALF);
    assign full_tick = (clk_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_set   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (rxd_s != UART_IDLE_LVL) state_nx = ST_START;
            end
            ST_START: begin
                // Mid-start resample: a line back at idle here was only a glitch.
                if (half_tick) state_nx = (rxd_s == UART_IDLE_LVL) ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (full_tick && bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                    state_nx = ST_PARITY;
`else
                    state_nx = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (full_tick) begin
                    par_set  = (rxd_s != ^shift);
                    state_nx = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (full_tick) begin
                    if (rxd_s) begin
                        push     = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_nx  = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rxd_s) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                ST_START: begin
                    clk_cnt <= half_tick ? '0 : clk_cnt + 1'b1;
                    bit_idx <= '0;
                end
                ST_DATA, ST_PARITY, ST_STOP: begin
                    clk_cnt <= full_tick ? '0 : clk_cnt + 1'b1;
                    if (state == ST_DATA && full_tick) begin
                        shift   <= {rxd_s, shift[UART_DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                default: clk_cnt <= '0;
            endcase
        end
    end

    // rd_en pops in the same cycle, so a full FIFO only overruns when nobody is reading.
    assign ovr_set = push && fifo_full && !rd_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= ovr_set   ? 1'b1 : (err_clr ? 1'b0 : overrun);
            frame_err <= frame_set ? 1'b1 : (err_clr ? 1'b0 : frame_err);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) par_err <= 1'b0;
        else        par_err <= par_set ? 1'b1 : (err_clr ? 1'b0 : par_err);
    end
`endif

    uart_rx_sfifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (shift),
        .pop   (rd_en),
        .dout  (rd_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed and random bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int HALF  = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // Edges from the start-bit drive to the push edge: sync(2) + IDLE(1) + half bit + data/parity + stop.
    localparam int PUSH_EDGE = 3 + HALF + 1 + (8 + PB) * CPB + CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rxd = 1'b1;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic       fifo_full;
    logic       overrun;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       par_err;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rise_cyc = -1;
    int send_t0 = 0;
    logic prev_valid = 1'b0;

    logic [7:0] q[$];
    logic exp_ovr = 1'b0;
    logic exp_fe = 1'b0;
    logic exp_pe = 1'b0;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rx_valid  (rx_valid),
        .fifo_full (fifo_full),
        .overrun   (overrun),
        .frame_err (frame_err),
        .err_clr   (err_clr)
`ifdef UART_RX_PARITY_EN
        ,
        .par_err   (par_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = rx_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame; rd_en / err_clr can be pulsed exactly on the stop-sample cycle.
    task automatic send(input logic [7:0] b, input logic stop, input int stop_bits,
                        input logic rd_push, input logic clr_push, input logic par_flip);
        int nbits;
        nbits   = 9 + PB + stop_bits;
        send_t0 = cyc;
        for (int n = 0; n < nbits * CPB; n++) begin
            int k;
            k = n / CPB;
            if (k == 0)                    rxd = 1'b0;
            else if (k <= 8)               rxd = b[k-1];
            else if (PB == 1 && k == 9)    rxd = (^b) ^ par_flip;
            else                           rxd = stop;
            rd_en   = rd_push  && (n == PUSH_EDGE - 1);
            err_clr = clr_push && (n == PUSH_EDGE - 1);
            tick(1);
        end
        rxd     = 1'b1;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        tick(CPB);
    endtask

    task automatic model_rx(input logic [7:0] b, input logic stop_ok, input logic rd_push);
        if (rd_push && q.size() > 0) void'(q.pop_front());
        if (!stop_ok)                exp_fe = 1'b1;
        else if (q.size() < DEPTH)   q.push_back(b);
        else                         exp_ovr = 1'b1;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".rx_valid"},  rx_valid,  q.size() != 0);
        chk({tag, ".fifo_full"}, fifo_full, q.size() == DEPTH);
        chk({tag, ".overrun"},   overrun,   exp_ovr);
        chk({tag, ".frame_err"}, frame_err, exp_fe);
`ifdef UART_RX_PARITY_EN
        chk({tag, ".par_err"},   par_err,   exp_pe);
`endif
        if (q.size() != 0) chk({tag, ".rd_data"}, rd_data, q[0]);
    endtask

    task automatic pop_chk(input string tag);
        chk(tag, rd_data, q[0]);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        void'(q.pop_front());
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".rx_valid"},  rx_valid,  1'b0);
        chk({tag, ".fifo_full"}, fifo_full, 1'b0);
        chk({tag, ".overrun"},   overrun,   1'b0);
        chk({tag, ".frame_err"}, frame_err, 1'b0);
        chk({tag, ".rd_data"},   rd_data,   8'h00);
`ifdef UART_RX_PARITY_EN
        chk({tag, ".par_err"},   par_err,   1'b0);
`endif
    endtask

    initial begin
        logic [7:0] b;
        logic       rdp;

        tick(3);
        chk_zero("reset");
        reset = 1'b1;
        tick(2);

        // Single byte and push latency
        send(8'hA5, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        model_rx(8'hA5, 1'b1, 1'b0);
        chk("a5.latency", rise_cyc - send_t0, PUSH_EDGE);
        chk_state("a5");
        pop_chk("a5.pop");
        chk("a5.empty", rx_valid, 1'b0);

        // Start-bit glitch, then a byte proves the FSM is back in IDLE
        rxd = 1'b0;
        tick(2);
        rxd = 1'b1;
        tick(4 * CPB);
        chk_state("glitch");
        b = 8'($urandom);
        send(b, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        model_rx(b, 1'b1, 1'b0);
        chk("glitch.latency", rise_cyc - send_t0, PUSH_EDGE);
        chk_state("glitch.after");
        pop_chk("glitch.pop");

        // Break-length low stop bit; err_clr on the set cycle loses to the set
        send(8'h3C, 1'b0, 20, 1'b0, 1'b1, 1'b0);
        model_rx(8'h3C, 1'b0, 1'b0);
        chk_state("break");
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        exp_fe = 1'b0;
        chk_state("break.clr");
        send(8'h11, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        model_rx(8'h11, 1'b1, 1'b0);
        chk_state("after_break");
        pop_chk("after_break.pop");

        // Overrun with no reader
        for (int i = 1; i <= 5; i++) begin
            send(8'(i), 1'b1, 1, 1'b0, 1'b0, 1'b0);
            model_rx(8'(i), 1'b1, 1'b0);
            chk_state($sformatf("ovr%0d", i));
        end
        for (int i = 0; i < 4; i++) pop_chk($sformatf("ovr.pop%0d", i));
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        exp_ovr = 1'b0;
        chk_state("ovr.clr");

        // Full FIFO with a read on the push cycle: no overrun
        for (int i = 1; i <= 4; i++) begin
            send(8'(i), 1'b1, 1, 1'b0, 1'b0, 1'b0);
            model_rx(8'(i), 1'b1, 1'b0);
        end
        send(8'h05, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        model_rx(8'h05, 1'b1, 1'b1);
        chk_state("simul");
        for (int i = 0; i < 4; i++) pop_chk($sformatf("simul.pop%0d", i));
        chk_state("simul.drained");

        // Random bytes, random stop lengths and reads
        for (int i = 0; i < 12; i++) begin
            b   = 8'($urandom);
            rdp = ($urandom_range(3) == 0);
            send(b, 1'b1, 1 + $urandom_range(1), rdp, 1'b0, 1'b0);
            model_rx(b, 1'b1, rdp);
            chk_state($sformatf("rnd%0d", i));
            if ($urandom_range(1) == 1 && q.size() != 0) pop_chk($sformatf("rnd%0d.pop", i));
        end
        while (q.size() != 0) pop_chk("rnd.drain");

        // Reset in the middle of a frame
        send(8'h99, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        model_rx(8'h99, 1'b1, 1'b0);
        chk_state("pre_reset");
        rxd = 1'b0;
        tick(CPB);
        rxd = 1'b0;
        tick(CPB);
        rxd = 1'b1;
        tick(CPB + 3);
        reset = 1'b0;
        tick(2);
        chk_zero("mid_reset");
        q.delete();
        exp_ovr = 1'b0;
        exp_fe = 1'b0;
        exp_pe = 1'b0;
        rxd = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(2 * CPB);
        chk_state("post_reset");
        send(8'h55, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        model_rx(8'h55, 1'b1, 1'b0);
        chk_state("post_reset.55");
        pop_chk("post_reset.pop");

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1, 1'b0, 1'b0, 1'b1);
        model_rx(8'h07, 1'b1, 1'b0);
        exp_pe = 1'b1;
        chk_state("parity");
        pop_chk("parity.pop");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
